// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmit types and constants.
// UART_TX_PARITY_EN adds the PARITY state to the framer state type.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous power-of-two byte FIFO with occupancy, full and empty flags.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = level == (AW + 1)'(DEPTH);
    assign empty   = level == '0;
    assign rdata   = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: FIFO-buffered UART transmitter, LSB first, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     tx_data,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    input  logic                           bps_tick,
    output logic                           bps_start,
    output logic                           txd,
    output logic                           tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

    localparam int CW = $clog2(UART_DATA_BITS);

    tx_state_t                 state, state_n;
    logic [UART_DATA_BITS-1:0] fifo_data, shift, shift_n;
    logic [CW-1:0]             bit_cnt, bit_cnt_n;
    logic                      stop_cnt, stop_cnt_n, txd_n;
    logic                      fifo_full, fifo_empty, pop, last_stop;
`ifdef UART_TX_PARITY_EN
    logic                      parity, parity_n;
`endif

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (pop),
        .rdata (fifo_data),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_ready  = !fifo_full;
    assign bps_start = state != IDLE;
    assign tx_busy   = (state != IDLE) || (fifo_level != '0);
    assign last_stop = (state == STOP) && bps_tick && (stop_cnt == 1'(STOP_BITS - 1));
    // Loading from IDLE or straight out of the final stop bit keeps frames gapless
    assign pop       = !fifo_empty && ((state == IDLE) || last_stop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            txd      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            txd      <= txd_n;
`ifdef UART_TX_PARITY_EN
            parity   <= parity_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        txd_n      = txd;
`ifdef UART_TX_PARITY_EN
        parity_n   = parity;
`endif
        if (pop) begin
            state_n = START;
            shift_n = fifo_data;
            txd_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_n = ^fifo_data;
`endif
        end else if (bps_tick) begin
            case (state)
                START: begin
                    state_n   = DATA;
                    txd_n     = shift[0];
                    bit_cnt_n = '0;
                end
                DATA: begin
                    if (bit_cnt == CW'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        txd_n   = parity;
`else
                        state_n    = STOP;
                        txd_n      = UART_IDLE_LEVEL;
                        stop_cnt_n = 1'b0;
`endif
                    end else begin
                        shift_n   = shift >> 1;
                        bit_cnt_n = bit_cnt + 1'b1;
                        txd_n     = shift[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state_n    = STOP;
                    txd_n      = UART_IDLE_LEVEL;
                    stop_cnt_n = 1'b0;
                end
`endif
                STOP: begin
                    if (last_stop) state_n = IDLE;
                    else stop_cnt_n = stop_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: queue-of-line-bits model checked every cycle, plus directed frame captures.
// Expected frames follow UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_framer;

    localparam int DEPTH = 4;
    localparam int DIV   = 10;
    localparam int LIMIT = 3000;

`ifdef UART_TX_PARITY_EN
    localparam int          FN  = 11;
    localparam int          F2N = 12;
    localparam logic [31:0] E55 = 32'h4AA;
    localparam logic [31:0] E07 = 32'h60E;
    localparam logic [31:0] EB2B = 32'h20F540;
    localparam logic [31:0] EFF = 32'hDFE;
`else
    localparam int          FN  = 10;
    localparam int          F2N = 11;
    localparam logic [31:0] E55 = 32'h2AA;
    localparam logic [31:0] E07 = 32'h20E;
    localparam logic [31:0] EB2B = 32'h87B40;
    localparam logic [31:0] EFF = 32'h7FE;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic [7:0] tx_data2 = '0;
    logic       tx_valid = 1'b0;
    logic       tx_valid2 = 1'b0;
    logic       tick_en = 1'b1;
    logic       tx_ready, bps_start, txd, tx_busy, bps_tick;
    logic       tx_ready2, bps_start2, txd2, tx_busy2, bps_tick2;
    logic [2:0] fifo_level, fifo_level2;
    int         div_cnt, div_cnt2;
    int         checks = 0;
    int         errors = 0;
    logic       exp_q[$];
    bit         mid = 1'b0;

    always #5 clk = ~clk;

    uart_tx_framer #(.FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bps_tick(bps_tick), .bps_start(bps_start), .txd(txd), .tx_busy(tx_busy), .fifo_level(fifo_level)
    );

    uart_tx_framer #(.FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .bps_tick(bps_tick2), .bps_start(bps_start2), .txd(txd2), .tx_busy(tx_busy2), .fifo_level(fifo_level2)
    );

    // Baud dividers: run only while bps_start is high, one tick every DIV clocks
    always @(posedge clk or negedge rst_n)
        if (!rst_n) div_cnt <= 0;
        else div_cnt <= (!bps_start || div_cnt == DIV - 1) ? 0 : div_cnt + 1;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) div_cnt2 <= 0;
        else div_cnt2 <= (!bps_start2 || div_cnt2 == DIV - 1) ? 0 : div_cnt2 + 1;

    assign bps_tick  = tick_en && bps_start && div_cnt == DIV - 1;
    assign bps_tick2 = bps_start2 && div_cnt2 == DIV - 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(^b);
`endif
        exp_q.push_back(1'b1);
    endtask

    // Model: the head of exp_q is the bit the line must carry right now
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mid = 1'b0;
        end else begin
            check("ready_vs_level", tx_ready, fifo_level < 3'(DEPTH));
            if (exp_q.size() == 0) begin
                check("idle_bps_start", bps_start, 0);
                check("idle_txd", txd, 1);
                check("idle_busy", tx_busy, 0);
            end else begin
                if (mid) check("frame_bps_start", bps_start, 1);
                check("line_bit", txd, bps_start ? exp_q[0] : 1'b1);
            end
            if (bps_tick && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                mid = exp_q.size() > 0;
            end
            if (tx_valid && tx_ready) push_frame(tx_data);
        end
    end

    task automatic send(input bit two, input logic [7:0] b);
        @(posedge clk); #1;
        if (two) begin tx_data2 = b; tx_valid2 = 1'b1; end
        else begin tx_data = b; tx_valid = 1'b1; end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_valid2 = 1'b0;
    endtask

    // Records the line at every tick until bps_start falls after having risen
    task automatic capture(input bit two, output logic [31:0] bits, output int n);
        int  cyc;
        bit  seen;
        cyc = 0;
        seen = 1'b0;
        bits = '0;
        n = 0;
        while (cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (two ? bps_start2 : bps_start) seen = 1'b1;
            if ((two ? bps_tick2 : bps_tick) && n < 32) begin
                bits[n] = two ? txd2 : txd;
                n++;
            end
            if (seen && !(two ? bps_start2 : bps_start)) break;
        end
        check("capture_done", cyc < LIMIT, 1);
    endtask

    initial begin
        logic [31:0] bits;
        int          n, acc, cyc, ticks, seen;
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_bps_start", bps_start, 0);
        check("rst_level", fifo_level, 0);
        check("rst_busy", tx_busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", tx_ready, 1);

        send(1'b0, 8'h55);
        capture(1'b0, bits, n);
        check("f55_ticks", n, FN);
        check("f55_bits", bits, E55);
        check("f55_busy_after", tx_busy, 0);

        send(1'b0, 8'h07);
        capture(1'b0, bits, n);
        check("f07_ticks", n, FN);
        check("f07_bits", bits, E07);

        @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'hA0;
        @(posedge clk); #1 tx_data = 8'h0F;
        @(posedge clk); #1 tx_valid = 1'b0;
        capture(1'b0, bits, n);
        check("b2b_ticks", n, 2 * FN);
        check("b2b_bits", bits, EB2B);

        tick_en = 1'b0;
        acc = 0;
        @(posedge clk); #1 tx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tx_data = 8'h10 + 8'(i);
            @(negedge clk);
            if (tx_ready) acc++;
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        @(negedge clk);
        check("fill_accepted", acc, DEPTH + 1);
        check("fill_level", fifo_level, DEPTH);
        check("fill_ready", tx_ready, 0);
        check("fill_busy", tx_busy, 1);
        @(posedge clk); #1 tick_en = 1'b1;
        cyc = 0;
        while (tx_busy && cyc < LIMIT) begin @(negedge clk); cyc++; end
        check("drain_done", cyc < LIMIT, 1);

        send(1'b0, 8'hF0);
        send(1'b0, 8'hAB);
        ticks = 0;
        cyc = 0;
        while (ticks < 4 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (bps_tick) ticks++;
        end
        check("bit3_reached", cyc < LIMIT, 1);
        @(posedge clk); #1;
        check("bit3_txd", txd, 0);
        rst_n = 1'b0;
        #1;
        check("abort_txd", txd, 1);
        check("abort_bps_start", bps_start, 0);
        check("abort_level", fifo_level, 0);
        check("abort_busy", tx_busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (bps_start || tx_busy) seen++;
        end
        check("no_resume", seen, 0);
        check("post_rst_level", fifo_level, 0);

        send(1'b1, 8'hFF);
        capture(1'b1, bits, n);
        check("stop2_ticks", n, F2N);
        check("stop2_bits", bits, EFF);
        check("stop2_idle_busy", tx_busy2, 0);
        check("stop2_idle_line", txd2, 1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
